vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions.
//   rgb_t      : 12-bit {r,g,b} 4:4:4 colour word
//   timing_t   : one axis of a video mode (visible/front/sync/back)
//   mode sets  : 800x600@72, 640x480@60, 1024x768@60 (H and V groups)
//   whole_len(): total line/frame length from the four segment lengths
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic [15:0] visible;
        logic [15:0] front;
        logic [15:0] sync;
        logic [15:0] back;
    } timing_t;

    localparam timing_t M800X600_72_H  = '{visible: 16'd800,  front: 16'd56, sync: 16'd120, back: 16'd64};
    localparam timing_t M800X600_72_V  = '{visible: 16'd600,  front: 16'd37, sync: 16'd6,   back: 16'd23};
    localparam timing_t M640X480_60_H  = '{visible: 16'd640,  front: 16'd16, sync: 16'd96,  back: 16'd48};
    localparam timing_t M640X480_60_V  = '{visible: 16'd480,  front: 16'd10, sync: 16'd2,   back: 16'd33};
    localparam timing_t M1024X768_60_H = '{visible: 16'd1024, front: 16'd24, sync: 16'd136, back: 16'd160};
    localparam timing_t M1024X768_60_V = '{visible: 16'd768,  front: 16'd3,  sync: 16'd6,   back: 16'd29};

    function automatic int unsigned whole_len(input int unsigned visible,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline used to align raster control bits with
// the pixel data returned by the fetch source.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears every stage
//   din   : W-bit input word
//   dout  : din delayed by DEPTH cycles (combinational pass when DEPTH=0)
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic clk_rst_unused;
            assign clk_rst_unused = clk ^ rst_n;
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] stg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg <= '0;
                end else begin
                    stg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
                end
            end

            assign dout = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with a latency-compensated fetch port.
//   CLOCK, RESET_N     : pixel clock, asynchronous active-low reset
//   FETCH_EN/X/Y       : visible-pixel request, issued LEAD cycles before
//                        the returned PIXEL is expected
//   PIXEL              : {R,G,B} 4:4:4 returned LEAD cycles after FETCH_EN
//   VGA_R/G/B          : registered colour, forced to 0 while blanked
//   VGA_HS/VGA_VS      : registered sync at the configured polarity
//   FRAME_START        : pulse on the first visible pixel of a frame
//   LINE_START         : pulse on the first visible pixel of each line
// Line order from x=0 is back porch, visible, front porch, sync; the frame
// uses the same order from y=0.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FRONT   = 56,
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BACK    = 64,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FRONT   = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BACK    = 23,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int          LEAD      = 2,
    parameter int          CW        = 11
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    output logic          FETCH_EN,
    output logic [CW-1:0] FETCH_X,
    output logic [CW-1:0] FETCH_Y,
    input  logic [11:0]   PIXEL,
    output logic [3:0]    VGA_R,
    output logic [3:0]    VGA_G,
    output logic [3:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          FRAME_START,
    output logic          LINE_START
);

    localparam int unsigned H_WHOLE = whole_len(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_WHOLE = whole_len(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CW-1:0] H_MAX     = CW'(H_WHOLE - 1);
    localparam logic [CW-1:0] V_MAX     = CW'(V_WHOLE - 1);
    localparam logic [CW-1:0] H_DE_LO   = CW'(H_BACK);
    localparam logic [CW-1:0] H_DE_HI   = CW'(H_BACK + H_VISIBLE);
    localparam logic [CW-1:0] V_DE_LO   = CW'(V_BACK);
    localparam logic [CW-1:0] V_DE_HI   = CW'(V_BACK + V_VISIBLE);
    localparam logic [CW-1:0] H_SYNC_LO = CW'(H_BACK + H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] V_SYNC_LO = CW'(V_BACK + V_VISIBLE + V_FRONT);

    // Raster counters
    logic [CW-1:0] x, y;
    logic          x_last, y_last;

    assign x_last = (x == H_MAX);
    assign y_last = (y == V_MAX);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_last ? '0 : x + 1'b1;
            if (x_last) y <= y_last ? '0 : y + 1'b1;
        end
    end

    // Stage F: decode the counters into fetch request and raw control bits
    logic h_de, v_de, de_c;
    logic hs_f, vs_f, frame_f, line_f;

    assign h_de = (x >= H_DE_LO) && (x < H_DE_HI);
    assign v_de = (y >= V_DE_LO) && (y < V_DE_HI);
    assign de_c = h_de && v_de;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            FETCH_EN <= 1'b0;
            FETCH_X  <= '0;
            FETCH_Y  <= '0;
            hs_f     <= 1'b0;
            vs_f     <= 1'b0;
            frame_f  <= 1'b0;
            line_f   <= 1'b0;
        end else begin
            FETCH_EN <= de_c;
            FETCH_X  <= de_c ? x - H_DE_LO : '0;
            FETCH_Y  <= de_c ? y - V_DE_LO : '0;
            hs_f     <= (x >= H_SYNC_LO);
            vs_f     <= (y >= V_SYNC_LO);
            frame_f  <= (x == H_DE_LO) && (y == V_DE_LO);
            line_f   <= (x == H_DE_LO) && v_de;
        end
    end

    // Hold control bits back by LEAD cycles so they meet the returned PIXEL
    logic [4:0] ctl_f, ctl_d;
    logic       de_d, hs_d, vs_d, frame_d, line_d;

    assign ctl_f = {line_f, frame_f, vs_f, hs_f, FETCH_EN};

    vga_delay_line #(.W(5), .DEPTH(LEAD)) u_dly (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .din   (ctl_f),
        .dout  (ctl_d)
    );

    assign {line_d, frame_d, vs_d, hs_d, de_d} = ctl_d;

    // Output stage
    rgb_t pix;
    assign pix = PIXEL;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            FRAME_START <= 1'b0;
            LINE_START  <= 1'b0;
        end else begin
            VGA_R       <= de_d ? pix.r : 4'h0;
            VGA_G       <= de_d ? pix.g : 4'h0;
            VGA_B       <= de_d ? pix.b : 4'h0;
            VGA_HS      <= ~(hs_d ^ HS_POL);
            VGA_VS      <= ~(vs_d ^ VS_POL);
            FRAME_START <= frame_d;
            LINE_START  <= line_d;
        end
    end

endmodule
